// File: rtl/rs_wakeup_select.sv
// Reservation station for one ALU class: holds renamed ops, snoops NRCDB result buses,
// captures operands, and issues the oldest fully-ready entry over a valid/ready handshake.

module rs_entry #(
  parameter int BW = 32,
  parameter int NS = 2,
  parameter int NC = 2,
  parameter int TW = 6,
  parameter int OW = 3,
  parameter int RW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   clear,
  input  logic                   dec,
  input  logic [RW-1:0]          load_rank,
  input  logic [OW-1:0]          d_opc,
  input  logic [TW-1:0]          d_dst,
  input  logic [NS-1:0]          d_rdy,
  input  logic [NS-1:0][TW-1:0]  d_tag,
  input  logic [NS-1:0][BW-1:0]  d_val,
  input  logic [NC-1:0]          cdb_valid,
  input  logic [NC-1:0][TW-1:0]  cdb_tag,
  input  logic [NC-1:0][BW-1:0]  cdb_data,
  output logic                   valid,
  output logic                   ready,
  output logic [RW-1:0]          rank,
  output logic [OW-1:0]          opc,
  output logic [TW-1:0]          dst_tag,
  output logic [NS-1:0][BW-1:0]  src_val
);
  logic [NS-1:0]          rdy_q, c_rdy, n_rdy;
  logic [NS-1:0][TW-1:0]  tag_q, c_tag;
  logic [NS-1:0][BW-1:0]  val_q, c_val, n_val;

  // Wakeup runs on either the stored sources or the incoming dispatch sources,
  // which gives dispatch bypass for free.
  assign c_rdy = load ? d_rdy : rdy_q;
  assign c_tag = load ? d_tag : tag_q;
  assign c_val = load ? d_val : val_q;

  always_comb begin
    n_rdy = c_rdy;
    n_val = c_val;
    for (int s = 0; s < NS; s++) begin
      if (!c_rdy[s]) begin
        // descending scan so the lowest matching bus index is written last
        for (int b = NC - 1; b >= 0; b--) begin
          if (cdb_valid[b] && (cdb_tag[b] == c_tag[s])) begin
            n_rdy[s] = 1'b1;
            n_val[s] = cdb_data[b];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid   <= 1'b0;
      rank    <= '0;
      opc     <= '0;
      dst_tag <= '0;
      rdy_q   <= '0;
      tag_q   <= '0;
      val_q   <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid   <= 1'b1;
        rank    <= load_rank;
        opc     <= d_opc;
        dst_tag <= d_dst;
      end else if (clear) begin
        valid <= 1'b0;
      end else if (dec) begin
        rank <= rank - 1'b1;
      end
      rdy_q <= n_rdy;
      tag_q <= c_tag;
      val_q <= n_val;
    end
  end

  assign ready   = valid & (&rdy_q);
  assign src_val = val_q;
endmodule

module rs_wakeup_select #(
  parameter int BITWIDTH    = 32,
  parameter int RS_DEPTH    = 8,
  parameter int NRSOURCEREG = 2,
  parameter int NRCDB       = 2,
  parameter int TAG_WIDTH   = 6,
  parameter int OPC_WIDTH   = 3,
  localparam int OCC_W      = $clog2(RS_DEPTH + 1),
  localparam int RW         = $clog2(RS_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  logic [OPC_WIDTH-1:0]            disp_opc,
  input  logic [TAG_WIDTH-1:0]            disp_dst_tag,
  input  logic [NRSOURCEREG-1:0]          disp_src_rdy,
  input  logic [NRSOURCEREG*TAG_WIDTH-1:0] disp_src_tag,
  input  logic [NRSOURCEREG*BITWIDTH-1:0] disp_src_val,
  input  logic [NRCDB-1:0]                cdb_valid,
  input  logic [NRCDB*TAG_WIDTH-1:0]      cdb_tag,
  input  logic [NRCDB*BITWIDTH-1:0]       cdb_data,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [OPC_WIDTH-1:0]            issue_opc,
  output logic [TAG_WIDTH-1:0]            issue_dst_tag,
  output logic [NRSOURCEREG*BITWIDTH-1:0] issue_src_val,
  output logic [OCC_W-1:0]                occupancy
);
  logic [NRSOURCEREG-1:0][TAG_WIDTH-1:0]  d_tag;
  logic [NRSOURCEREG-1:0][BITWIDTH-1:0]   d_val;
  logic [NRCDB-1:0][TAG_WIDTH-1:0]        c_tag;
  logic [NRCDB-1:0][BITWIDTH-1:0]         c_data;
  assign d_tag  = disp_src_tag;
  assign d_val  = disp_src_val;
  assign c_tag  = cdb_tag;
  assign c_data = cdb_data;

  logic [RS_DEPTH-1:0]                               e_valid, e_ready, alloc, sel, age_sel, hold_sel, dec;
  logic [RS_DEPTH-1:0][RW-1:0]                       e_rank;
  logic [RS_DEPTH-1:0][OPC_WIDTH-1:0]                e_opc;
  logic [RS_DEPTH-1:0][TAG_WIDTH-1:0]                e_dst;
  logic [RS_DEPTH-1:0][NRSOURCEREG-1:0][BITWIDTH-1:0] e_val;
  logic [RW-1:0]                                     sel_rank, load_rank;
  logic [NRSOURCEREG-1:0][BITWIDTH-1:0]              sel_val;
  logic                                              disp_fire, issue_fire, hold_q;

  assign disp_ready = (occupancy != OCC_W'(RS_DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = issue_valid && issue_ready && !flush;
  assign load_rank  = RW'(occupancy - OCC_W'(issue_fire));

  // lowest-index free slot
  always_comb begin
    alloc = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!e_valid[i]) alloc = '0 | (RS_DEPTH'(1) << i);
  end

  // oldest ready: a ready entry with no ready entry of lower rank
  always_comb begin
    age_sel = e_ready;
    for (int i = 0; i < RS_DEPTH; i++)
      for (int j = 0; j < RS_DEPTH; j++)
        if (e_ready[j] && (e_rank[j] < e_rank[i])) age_sel[i] = 1'b0;
  end

  // A stalled presentation is frozen so a later-woken older entry cannot swap it out.
  assign sel = hold_q ? hold_sel : age_sel;

  always_comb begin
    issue_opc     = '0;
    issue_dst_tag = '0;
    sel_val       = '0;
    sel_rank      = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (sel[i]) begin
        issue_opc     = issue_opc     | e_opc[i];
        issue_dst_tag = issue_dst_tag | e_dst[i];
        sel_val       = sel_val       | e_val[i];
        sel_rank      = sel_rank      | e_rank[i];
      end
    end
  end
  assign issue_valid   = |e_ready;
  assign issue_src_val = sel_val;

  always_comb begin
    dec = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      dec[i] = issue_fire && e_valid[i] && (e_rank[i] > sel_rank);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
      hold_q    <= 1'b0;
      hold_sel  <= '0;
    end else begin
      hold_q   <= issue_valid && !issue_ready && !flush;
      hold_sel <= sel;
      if (flush)                       occupancy <= '0;
      else if (disp_fire && !issue_fire) occupancy <= occupancy + 1'b1;
      else if (issue_fire && !disp_fire) occupancy <= occupancy - 1'b1;
    end
  end

  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_ent
    rs_entry #(
      .BW(BITWIDTH), .NS(NRSOURCEREG), .NC(NRCDB),
      .TW(TAG_WIDTH), .OW(OPC_WIDTH), .RW(RW)
    ) u_ent (
      .clk(clk), .rst(rst), .flush(flush),
      .load(disp_fire && alloc[g]),
      .clear(issue_fire && sel[g]),
      .dec(dec[g]),
      .load_rank(load_rank),
      .d_opc(disp_opc), .d_dst(disp_dst_tag), .d_rdy(disp_src_rdy),
      .d_tag(d_tag), .d_val(d_val),
      .cdb_valid(cdb_valid), .cdb_tag(c_tag), .cdb_data(c_data),
      .valid(e_valid[g]), .ready(e_ready[g]), .rank(e_rank[g]),
      .opc(e_opc[g]), .dst_tag(e_dst[g]), .src_val(e_val[g])
    );
  end
endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed bench for rs_wakeup_select: reset, wakeup, age order, full, bypass, flush.

module tb_rs_wakeup_select;
  logic        clk = 0, rst = 0, flush = 0;
  logic        disp_valid = 0, disp_ready;
  logic [2:0]  disp_opc = 0;
  logic [5:0]  disp_dst_tag = 0;
  logic [1:0]  disp_src_rdy = 0;
  logic [11:0] disp_src_tag = 0;
  logic [63:0] disp_src_val = 0;
  logic [1:0]  cdb_valid = 0;
  logic [11:0] cdb_tag = 0;
  logic [63:0] cdb_data = 0;
  logic        issue_valid, issue_ready = 0;
  logic [2:0]  issue_opc;
  logic [5:0]  issue_dst_tag;
  logic [63:0] issue_src_val;
  logic [3:0]  occupancy;
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  rs_wakeup_select dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opc(disp_opc),
    .disp_dst_tag(disp_dst_tag), .disp_src_rdy(disp_src_rdy),
    .disp_src_tag(disp_src_tag), .disp_src_val(disp_src_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opc(issue_opc),
    .issue_dst_tag(issue_dst_tag), .issue_src_val(issue_src_val),
    .occupancy(occupancy)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] opc, input logic [5:0] dst, input logic [1:0] rdy,
                       input logic [5:0] t1, input logic [5:0] t0,
                       input logic [31:0] v1, input logic [31:0] v0);
    disp_valid = 1; disp_opc = opc; disp_dst_tag = dst; disp_src_rdy = rdy;
    disp_src_tag = {t1, t0}; disp_src_val = {v1, v0};
  endtask

  task automatic test_reset();
    rst = 0;
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    ncmp++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL reset_iv: got %b want 0", issue_valid); end
    ncmp++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL reset_dr: got %b want 1", disp_ready); end
    step(); rst = 1;
    // three pending ops, then an asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 6'(20 + i), 2'b00, 6'd61, 6'd62, 32'h0, 32'h0); step();
    end
    disp_valid = 0;
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd3) begin nerr++; $display("FAIL pre_rst_occ: got %0d want 3", occupancy); end
    #1 rst = 0; #1;
    ncmp++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
    ncmp++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL arst_iv: got %b want 0", issue_valid); end
    ncmp++; if (disp_ready !== 1'b1) begin nerr++; $display("FAIL arst_dr: got %b want 1", disp_ready); end
    step(); rst = 1;
  endtask

  task automatic test_wakeup();
    issue_ready = 1;
    drive(3'd1, 6'd1, 2'b10, 6'd0, 6'd5, 32'h10, 32'h0); step();
    drive(3'd2, 6'd2, 2'b11, 6'd0, 6'd0, 32'h2, 32'h1);
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL wk_a_pending: got %b want 0", issue_valid); end
    step();
    disp_valid = 0; cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd5}; cdb_data = {32'h0, 32'hAA};
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd2) begin nerr++; $display("FAIL wk_occ: got %0d want 2", occupancy); end
    ncmp++; if (issue_valid !== 1'b1 || issue_dst_tag !== 6'd2 || issue_opc !== 3'd2)
      begin nerr++; $display("FAIL wk_b_first: got v=%b dst=%0d opc=%0d want v=1 dst=2 opc=2", issue_valid, issue_dst_tag, issue_opc); end
    ncmp++; if (issue_src_val !== {32'h2, 32'h1}) begin nerr++; $display("FAIL wk_b_val: got %h want %h", issue_src_val, {32'h2, 32'h1}); end
    step();
    cdb_valid = 0;
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b1 || issue_dst_tag !== 6'd1)
      begin nerr++; $display("FAIL wk_a_next: got v=%b dst=%0d want v=1 dst=1", issue_valid, issue_dst_tag); end
    ncmp++; if (issue_src_val !== {32'h10, 32'hAA}) begin nerr++; $display("FAIL wk_a_val: got %h want %h", issue_src_val, {32'h10, 32'hAA}); end
    step();
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b0 || occupancy !== 4'd0)
      begin nerr++; $display("FAIL wk_empty: got v=%b occ=%0d want v=0 occ=0", issue_valid, occupancy); end
    step();
  endtask

  task automatic test_age();
    logic [5:0] exp [3];
    exp[0] = 6'd10; exp[1] = 6'd11; exp[2] = 6'd12;
    issue_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd3, exp[i], 2'b11, 6'd0, 6'd0, 32'(i), 32'(100 + i)); step();
    end
    disp_valid = 0;
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd3) begin nerr++; $display("FAIL age_occ: got %0d want 3", occupancy); end
    ncmp++; if (issue_dst_tag !== 6'd10) begin nerr++; $display("FAIL age_stall: got %0d want 10", issue_dst_tag); end
    step();
    issue_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ncmp++; if (issue_valid !== 1'b1 || issue_dst_tag !== exp[i] || issue_src_val !== {32'(i), 32'(100 + i)})
        begin nerr++; $display("FAIL age_order%0d: got v=%b dst=%0d want dst=%0d", i, issue_valid, issue_dst_tag, exp[i]); end
      step();
    end
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL age_drained: got %b want 0", issue_valid); end
    step();
  endtask

  task automatic test_full();
    issue_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive(3'd4, 6'(40 + i), 2'b10, 6'd0, 6'(50 + i), 32'h7, 32'h0); step();
    end
    disp_valid = 0;
    @(negedge clk);
    ncmp++; if (disp_ready !== 1'b0 || occupancy !== 4'd8)
      begin nerr++; $display("FAIL full: got dr=%b occ=%0d want dr=0 occ=8", disp_ready, occupancy); end
    ncmp++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL full_iv: got %b want 0", issue_valid); end
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd50}; cdb_data = {32'h0, 32'h3};
    step();
    cdb_valid = 0; issue_ready = 1;
    drive(3'd5, 6'd60, 2'b11, 6'd0, 6'd0, 32'h1, 32'h1);
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b1 || issue_dst_tag !== 6'd40)
      begin nerr++; $display("FAIL full_wake: got v=%b dst=%0d want v=1 dst=40", issue_valid, issue_dst_tag); end
    ncmp++; if (disp_ready !== 1'b0) begin nerr++; $display("FAIL full_noref: got %b want 0", disp_ready); end
    step();
    disp_valid = 0;
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd7 || disp_ready !== 1'b1)
      begin nerr++; $display("FAIL full_after: got occ=%0d dr=%b want occ=7 dr=1", occupancy, disp_ready); end
    ncmp++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL full_rejected: got %b want 0", issue_valid); end
    flush = 1; step(); flush = 0;
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL full_clean: got %0d want 0", occupancy); end
    step();
  endtask

  task automatic test_bypass();
    issue_ready = 1;
    drive(3'd6, 6'd3, 2'b01, 6'd9, 6'd0, 32'h0, 32'h7);
    cdb_valid = 2'b11; cdb_tag = {6'd9, 6'd8}; cdb_data = {32'h55, 32'h33};
    step();
    disp_valid = 0; cdb_valid = 0;
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b1 || issue_dst_tag !== 6'd3)
      begin nerr++; $display("FAIL byp_iv: got v=%b dst=%0d want v=1 dst=3", issue_valid, issue_dst_tag); end
    ncmp++; if (issue_src_val !== {32'h55, 32'h7}) begin nerr++; $display("FAIL byp_val: got %h want %h", issue_src_val, {32'h55, 32'h7}); end
    step();
    // both buses carry the same tag: bus 0 must win
    drive(3'd6, 6'd4, 2'b10, 6'd0, 6'd12, 32'h9, 32'h0);
    cdb_valid = 2'b11; cdb_tag = {6'd12, 6'd12}; cdb_data = {32'h77, 32'h66};
    step();
    disp_valid = 0; cdb_valid = 0;
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b1 || issue_src_val !== {32'h9, 32'h66})
      begin nerr++; $display("FAIL byp_prio: got v=%b val=%h want %h", issue_valid, issue_src_val, {32'h9, 32'h66}); end
    step();
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd0) begin nerr++; $display("FAIL byp_drain: got %0d want 0", occupancy); end
    step();
  endtask

  task automatic test_flush();
    issue_ready = 1;
    drive(3'd7, 6'd20, 2'b11, 6'd0, 6'd0, 32'h1, 32'h2); step();
    flush = 1;
    drive(3'd7, 6'd21, 2'b11, 6'd0, 6'd0, 32'h3, 32'h4);
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b1) begin nerr++; $display("FAIL fl_pre: got %b want 1", issue_valid); end
    step();
    flush = 0; disp_valid = 0;
    @(negedge clk);
    ncmp++; if (occupancy !== 4'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1)
      begin nerr++; $display("FAIL flush: got occ=%0d v=%b dr=%b want 0 0 1", occupancy, issue_valid, disp_ready); end
    step();
    @(negedge clk);
    ncmp++; if (issue_valid !== 1'b0 || occupancy !== 4'd0)
      begin nerr++; $display("FAIL fl_stays: got v=%b occ=%0d want 0 0", issue_valid, occupancy); end
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_age();
    test_full();
    test_bypass();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
